fpu_issue: RTL
==============

Name: fpu_issue

Overview:
- Issue/sequencing stage directly upstream of the FPU datapath.
- Accepts one RV32F arithmetic, compare, convert or move instruction at a time from the integer core.
- Owns the 32x32 floating-point register file and reads rs1/rs2/rs3. Integer-sourced operands are substituted.
- Launches the FPU, waits on its busy flag, then writes the result to the FP register file or returns it to the integer core.

Parameters:
- FLEN, 32, floating-point register/operand width.
- XLEN, 32, integer operand/result width.
- NFREG, 32, number of FP registers (index width 5, fixed).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- issue_valid_i  in  1  instruction presented
- issue_ready_o  out  1  stage can accept (IDLE)
- instr_i  in  32  instruction word
- xrs1_i  in  32  integer rs1 value (FMV.W.X, FCVT.S.W[U])
- fpuEnable_o  out  1  one-cycle launch strobe to FPU
- fpuInstr_o  out  32  held instruction to FPU
- fpuRs1_o / fpuRs2_o / fpuRs3_o  out  32 each  held operands to FPU
- fpuBusy_i  in  1  FPU busy (registered in FPU; valid the cycle after launch)
- fpuOut_i  in  32  FPU result
- fLoadEn_i  in  1  FLW writeback request
- fLoadRd_i  in  5  FLW destination
- fLoadData_i  in  32  FLW data
- fLoadReady_o  out  1  load write accepted this cycle
- fStoreIdx_i  in  5  FSW source index
- fStoreData_o  out  32  f[fStoreIdx_i], combinational, includes same-cycle load bypass
- xWrEn_o  out  1  integer writeback strobe
- xWrRd_o  out  5  integer destination
- xWrData_o  out  32  integer result
- done_o  out  1  one-cycle completion pulse
- illegal_o  out  1  qualifies done_o: instruction rejected

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE. All FP registers become 0x00000000.
  - Reset values: issue_ready_o=1, fLoadReady_o=1; all other outputs 0 (fpuEnable_o, done_o, xWrEn_o, illegal_o, fpu* operand/instr regs).
  - Reset mid-operation abandons the instruction with no writeback.
- Instruction classes, by instr[6:2] and funct5 = instr[31:27]:
  - FMA: opcode 100xx.
  - OP-FP: opcode 10100.
  - Any other opcode is illegal.
  - INT_SRC: funct5 11010 or 11110. rs1 operand = xrs1_i.
  - INT_DST: funct5 10100, 11000 or 11100. Result goes to integer rd.
  - Everything else writes f[rd].
- States: IDLE -> LAUNCH -> WAIT -> WB -> IDLE.
- IDLE:
  - issue_ready_o=1.
  - On issue_valid_i, capture instr and the three operands read from the register file.
  - Same-cycle load bypass: if fLoadEn_i and fLoadRd_i matches a source index, that operand takes fLoadData_i.
  - Illegal opcode: go to WB with illegal_o=1 and no writes.
- LAUNCH:
  - If fpuBusy_i=1 (stale after reset), hold.
  - Otherwise assert fpuEnable_o for exactly one cycle and go to WAIT.
- WAIT:
  - Operands and instr held stable.
  - When fpuBusy_i=0, capture fpuOut_i and go to WB.
  - The first WAIT cycle already reflects FPU busy.
- WB:
  - done_o=1 for one cycle.
  - INT_DST: xWrEn_o=1, xWrRd_o=rd, xWrData_o=result.
  - Otherwise write f[rd]=result.
  - fLoadReady_o=0 in WB only; a load presented in WB retries next cycle.
- Loads are accepted in all other states.
- A load during WAIT to the same rd is later overwritten by WB; this is the required program order.
- Latency:
  - Single-cycle FPU op: accept cycle 0, launch cycle 1, WAIT cycle 2, done cycle 3, ready cycle 4.
  - Multi-cycle op: done arrives 1 cycle after busy falls.
  - Illegal: done at cycle 1.
- issue_valid_i outside IDLE is ignored; the producer holds it until ready.
- f0 is a normal register (not hardwired).

Decomposition:
- Package fpu_pkg holds:
  - opcode constants (OP_FP=5'b10100, FMA prefix 3'b100);
  - funct5 constants for INT_SRC/INT_DST classes;
  - state enum {IDLE, LAUNCH, WAIT, WB}.
- Sub-module fp_regfile: 32x32, three async read ports plus store read port, one write port, load write port, internal arbitration and bypass.

Test Plan:
- Reset, then load f1=0x3F800000 and f2=0x40000000; issue FADD.S f3,f1,f2 (0x002081D3), single-cycle FPU model -> fpuEnable_o at cycle 1, done_o at cycle 3, f3 reads 0x40400000, xWrEn_o=0.
- Issue FEQ.S x5,f1,f1 (0xA010A2D3), FPU returns 1 -> xWrEn_o=1, xWrRd_o=5, xWrData_o=1, FP file unchanged.
- Issue FMV.W.X f4,x6 (0xF0030253), xrs1_i=0xDEADBEEF -> fpuRs1_o=0xDEADBEEF; f4=0xDEADBEEF after done.
- FDIV with FPU busy for 10 cycles, load to f7 during WAIT, load presented in WB -> operands stable throughout; done 1 cycle after busy falls; WB-cycle load deferred one cycle; both writes land.
- Issue with same-cycle load to f1 (0x40800000) reading f1 -> fpuRs1_o=0x40800000.
- Assert reset_i during WAIT, hold fpuBusy_i=1 after release, then issue -> no writeback; LAUNCH holds until busy falls.
- Opcode 0110011 -> done_o and illegal_o at cycle 1, no writes.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants, state encoding and instruction-class decode for the FPU issue stage.
package fpu_pkg;

  localparam int unsigned FLEN   = 32;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NFREG  = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [4:0] OP_FP      = 5'b10100;
  localparam logic [2:0] OP_FMA_PFX = 3'b100;

  localparam logic [4:0] F5_FCVT_S_W = 5'b11010;
  localparam logic [4:0] F5_FMV_W_X  = 5'b11110;
  localparam logic [4:0] F5_FCMP     = 5'b10100;
  localparam logic [4:0] F5_FCVT_W_S = 5'b11000;
  localparam logic [4:0] F5_FMV_X_W  = 5'b11100;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, WB} state_e;

  typedef struct packed {
    logic legal;
    logic int_src;
    logic int_dst;
  } iclass_t;

  // Integer source/destination classes only exist within OP-FP.
  function automatic iclass_t decode(input logic [4:0] opcode, input logic [4:0] funct5);
    iclass_t c;
    logic    is_fma;
    logic    is_opfp;
    is_fma    = (opcode[4:2] == OP_FMA_PFX);
    is_opfp   = (opcode == OP_FP);
    c.legal   = is_fma || is_opfp;
    c.int_src = is_opfp && ((funct5 == F5_FCVT_S_W) || (funct5 == F5_FMV_W_X));
    c.int_dst = is_opfp && ((funct5 == F5_FCMP) || (funct5 == F5_FCVT_W_S) ||
                            (funct5 == F5_FMV_X_W));
    return c;
  endfunction

endpackage

// File: rtl/fp_regfile.sv
// 32x32 FP register file: three operand reads, one store read, result write and FLW write.
module fp_regfile
  import fpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  input  logic [REG_AW-1:0] ra3_i,
  output logic [FLEN-1:0]   rs1_data_c_o,
  output logic [FLEN-1:0]   rs2_data_c_o,
  output logic [FLEN-1:0]   rs3_data_c_o,
  input  logic [REG_AW-1:0] st_idx_i,
  output logic [FLEN-1:0]   st_data_c_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [FLEN-1:0]   wdata_i,
  input  logic              ld_en_i,
  input  logic              ld_ok_i,
  input  logic [REG_AW-1:0] ld_addr_i,
  input  logic [FLEN-1:0]   ld_data_i
);

  logic [FLEN-1:0] regs_q [NFREG];
  logic            ld_acc;

  assign ld_acc = ld_en_i && ld_ok_i;

  // Accepted loads forward to every read port in the same cycle.
  assign rs1_data_c_o = (ld_acc && (ld_addr_i == ra1_i))    ? ld_data_i : regs_q[ra1_i];
  assign rs2_data_c_o = (ld_acc && (ld_addr_i == ra2_i))    ? ld_data_i : regs_q[ra2_i];
  assign rs3_data_c_o = (ld_acc && (ld_addr_i == ra3_i))    ? ld_data_i : regs_q[ra3_i];
  assign st_data_c_o  = (ld_acc && (ld_addr_i == st_idx_i)) ? ld_data_i : regs_q[st_idx_i];

  // Result writes only occur while loads are blocked, so priority is a safety net.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NFREG; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end else if (ld_acc) begin
      regs_q[ld_addr_i] <= ld_data_i;
    end
  end

endmodule

// File: rtl/fpu_issue.sv
// Issue/sequencing stage ahead of the FPU: operand read, launch, busy wait and writeback.
module fpu_issue
  import fpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [31:0]       instr_i,
  input  logic [XLEN-1:0]   xrs1_i,
  output logic              fpuEnable_o,
  output logic [31:0]       fpuInstr_o,
  output logic [FLEN-1:0]   fpuRs1_o,
  output logic [FLEN-1:0]   fpuRs2_o,
  output logic [FLEN-1:0]   fpuRs3_o,
  input  logic              fpuBusy_i,
  input  logic [FLEN-1:0]   fpuOut_i,
  input  logic              fLoadEn_i,
  input  logic [REG_AW-1:0] fLoadRd_i,
  input  logic [FLEN-1:0]   fLoadData_i,
  output logic              fLoadReady_o,
  input  logic [REG_AW-1:0] fStoreIdx_i,
  output logic [FLEN-1:0]   fStoreData_o,
  output logic              xWrEn_o,
  output logic [REG_AW-1:0] xWrRd_o,
  output logic [XLEN-1:0]   xWrData_o,
  output logic              done_o,
  output logic              illegal_o
);

  state_e          state_q;
  iclass_t         cls_c;
  logic            int_dst_q;
  logic [FLEN-1:0] res_q;
  logic [FLEN-1:0] rf_rs1, rf_rs2, rf_rs3;
  logic            rf_we;

  assign cls_c = decode(instr_i[6:2], instr_i[31:27]);
  assign rf_we = (state_q == WB) && !illegal_o && !int_dst_q;

  // Launch strobe must respect the live busy flag so a stale FPU is never re-launched.
  assign fpuEnable_o = (state_q == LAUNCH) && !fpuBusy_i;

  fp_regfile u_rf (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .ra1_i        (instr_i[19:15]),
    .ra2_i        (instr_i[24:20]),
    .ra3_i        (instr_i[31:27]),
    .rs1_data_c_o (rf_rs1),
    .rs2_data_c_o (rf_rs2),
    .rs3_data_c_o (rf_rs3),
    .st_idx_i     (fStoreIdx_i),
    .st_data_c_o  (fStoreData_o),
    .we_i         (rf_we),
    .waddr_i      (fpuInstr_o[11:7]),
    .wdata_i      (res_q),
    .ld_en_i      (fLoadEn_i),
    .ld_ok_i      (fLoadReady_o),
    .ld_addr_i    (fLoadRd_i),
    .ld_data_i    (fLoadData_i)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      issue_ready_o <= 1'b1;
      fLoadReady_o  <= 1'b1;
      fpuInstr_o    <= '0;
      fpuRs1_o      <= '0;
      fpuRs2_o      <= '0;
      fpuRs3_o      <= '0;
      int_dst_q     <= 1'b0;
      res_q         <= '0;
      xWrEn_o       <= 1'b0;
      xWrRd_o       <= '0;
      xWrData_o     <= '0;
      done_o        <= 1'b0;
      illegal_o     <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      xWrEn_o   <= 1'b0;
      illegal_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue_valid_i) begin
            fpuInstr_o    <= instr_i;
            fpuRs1_o      <= cls_c.int_src ? xrs1_i : rf_rs1;
            fpuRs2_o      <= rf_rs2;
            fpuRs3_o      <= rf_rs3;
            int_dst_q     <= cls_c.int_dst;
            issue_ready_o <= 1'b0;
            if (cls_c.legal) begin
              state_q <= LAUNCH;
            end else begin
              state_q      <= WB;
              done_o       <= 1'b1;
              illegal_o    <= 1'b1;
              fLoadReady_o <= 1'b0;
            end
          end
        end
        LAUNCH: begin
          if (!fpuBusy_i) state_q <= WAIT;
        end
        WAIT: begin
          if (!fpuBusy_i) begin
            state_q      <= WB;
            res_q        <= fpuOut_i;
            done_o       <= 1'b1;
            fLoadReady_o <= 1'b0;
            if (int_dst_q) begin
              xWrEn_o   <= 1'b1;
              xWrRd_o   <= fpuInstr_o[11:7];
              xWrData_o <= fpuOut_i;
            end
          end
        end
        WB: begin
          state_q       <= IDLE;
          issue_ready_o <= 1'b1;
          fLoadReady_o  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
